// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped caches: FSM states, the word
// transfer size code and the address split helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        MISS,
        REFILL
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int ADDR_WIDTH          = 32;
    localparam int OFFSET_WIDTH        = 2;
    localparam int DEFAULT_INDEX_WIDTH = 10;

    // One word per line, so the tag is whatever remains above index and byte offset.
    function automatic int tag_width(input int index_width);
        return ADDR_WIDTH - OFFSET_WIDTH - index_width;
    endfunction

endpackage

// File: rtl/i_cache_array.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// One combinational read port and one synchronous write port.
module i_cache_array
    import cache_pkg::*;
#(
    parameter int  INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
    localparam int TAG_WIDTH   = tag_width(INDEX_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] rd_index,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_index,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [31:0]            wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    // Valid bits: cleared by reset, set when a line is refilled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data payload written on refill.
    // NOTE: payload arrays have no reset; the valid bit is the only thing that
    // must be known after reset, and leaving these unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped, read-only instruction cache between the core's sram-like
// instruction port and the memory-side sram-like bridge. Hits answer in one
// cycle; misses issue a single-word refill and forward the word to the core.
module i_cache_dm
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic [31:0] cpu_inst_rdata,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok,
    input  logic [31:0] cache_inst_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_WIDTH  = tag_width(INDEX_WIDTH);
    localparam int LINE_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

    state_t                  state;
    logic [LINE_WIDTH-1:0]   line_addr_q;   // word address of the outstanding miss
    logic [31:0]             rdata_q;       // last word returned to the core
    logic [31:0]             hit_cnt_q;
    logic [31:0]             miss_cnt_q;

    logic [INDEX_WIDTH-1:0]  lookup_index;
    logic [TAG_WIDTH-1:0]    lookup_tag;
    logic                    arr_valid;
    logic [TAG_WIDTH-1:0]    arr_tag;
    logic [31:0]             arr_data;
    logic                    hit;
    logic                    refill_done;

    assign lookup_index = cpu_inst_addr[INDEX_WIDTH+1:2];
    assign lookup_tag   = cpu_inst_addr[31:INDEX_WIDTH+2];
    assign hit          = arr_valid && (arr_tag == lookup_tag);
    assign refill_done  = (state == REFILL) && cache_inst_data_ok;

    i_cache_array #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (lookup_index),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (refill_done),
        .wr_index (line_addr_q[INDEX_WIDTH-1:0]),
        .wr_tag   (line_addr_q[LINE_WIDTH-1:INDEX_WIDTH]),
        .wr_data  (cache_inst_rdata)
    );

    // Request handshake FSM with its latched miss address, response word and counters.
    // NOTE: every register here uses <= so all of them see the pre-edge state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            line_addr_q <= '0;
            rdata_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_inst_req) begin
                        if (hit) begin
                            rdata_q   <= arr_data;
                            hit_cnt_q <= hit_cnt_q + 32'd1;
                            state     <= RESP;
                        end else begin
                            line_addr_q <= cpu_inst_addr[31:2];
                            miss_cnt_q  <= miss_cnt_q + 32'd1;
                            state       <= MISS;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                MISS: begin
                    // Memory data_ok cannot arrive before the address is taken.
                    if (cache_inst_addr_ok) begin
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (cache_inst_data_ok) begin
                        rdata_q <= cache_inst_rdata;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Requests are only taken in IDLE; reset masks acceptance while it is held.
    assign cpu_inst_addr_ok = (state == IDLE) && cpu_inst_req && !rst;
    assign cpu_inst_data_ok = (state == RESP) || refill_done;
    // Refill data bypasses the register so the miss answers in the data_ok cycle.
    assign cpu_inst_rdata   = refill_done ? cache_inst_rdata : rdata_q;

    assign cache_inst_req   = (state == MISS);
    assign cache_inst_wr    = 1'b0;
    assign cache_inst_size  = SIZE_WORD;
    assign cache_inst_addr  = {line_addr_q, 2'b00};
    assign cache_inst_wdata = 32'd0;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Write data and byte offset carry no information for word instruction fetches.
    logic unused_inputs;
    assign unused_inputs = ^{cpu_inst_wdata, cpu_inst_addr[1:0], cpu_inst_wr, cpu_inst_size};

    // The instruction side only ever issues word reads.
    assert property (@(posedge clk) disable iff (rst)
        cpu_inst_req |-> (!cpu_inst_wr && (cpu_inst_size == SIZE_WORD)))
        else $error("i_cache_dm: write or non-word request on instruction port");

endmodule

// File: tb/tb_i_cache_dm.sv
// Self-checking bench for i_cache_dm: directed vector table, reset during refill,
// streaming hits, counter wrap, then randomized accesses against a line-map model.
module tb_i_cache_dm;

    localparam int INDEX_WIDTH = 10;
    localparam int LINES       = 1 << INDEX_WIDTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_inst_req   = 1'b0;
    logic        cpu_inst_wr    = 1'b0;
    logic [1:0]  cpu_inst_size  = 2'b10;
    logic [31:0] cpu_inst_addr  = '0;
    logic [31:0] cpu_inst_wdata = '0;
    logic        cpu_inst_addr_ok, cpu_inst_data_ok;
    logic [31:0] cpu_inst_rdata;
    logic        cache_inst_req, cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr, cache_inst_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata   = '0;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_cache_dm #(.INDEX_WIDTH(INDEX_WIDTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_addr_ok (mem_addr_ok),
        .cache_inst_data_ok (mem_data_ok),
        .cache_inst_rdata   (mem_rdata),
        .hit_cnt            (hit_cnt),
        .miss_cnt           (miss_cnt)
    );

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h3C1D_0001;
        return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h9E37_79B9;
    endfunction

    // ---------------- memory-side responder ----------------
    bit          rand_mode = 1'b0;
    int          cur_ad = 0;
    int          cur_dd = 1;
    int          mphase = 0;
    int          mwait  = 0;
    bit          mfresh = 1'b1;
    logic [31:0] maddr  = '0;
    logic [31:0] mem_log[$];

    function automatic int pick_ad();
        return rand_mode ? int'($urandom_range(0, 3)) : cur_ad;
    endfunction

    function automatic int pick_dd();
        return rand_mode ? int'($urandom_range(1, 4)) : cur_dd;
    endfunction

    // Acts 2 time units after each edge; the main process samples at +3.
    always @(posedge clk) begin
        #2;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (rst) begin
            mphase = 0;
            mfresh = 1'b1;
        end else if (mphase == 0) begin
            if (cache_inst_req) begin
                if (mfresh) begin
                    mwait  = pick_ad();
                    mfresh = 1'b0;
                end
                if (mwait == 0) begin
                    mem_addr_ok = 1'b1;
                    maddr       = cache_inst_addr;
                    mem_log.push_back(cache_inst_addr);
                    mwait       = pick_dd();
                    mphase      = 1;
                end else begin
                    mwait--;
                end
            end
        end else begin
            if (mwait <= 1) begin
                mem_data_ok = 1'b1;
                mem_rdata   = mem_word(maddr);
                mphase      = 0;
                mfresh      = 1'b1;
            end else begin
                mwait--;
            end
        end
    end

    // ---------------- reference model: which word each line holds ----------------
    logic [31:0] model_line [int];
    logic [31:0] model_hits   = '0;
    logic [31:0] model_misses = '0;

    function automatic bit model_access(input logic [31:0] a);
        int          idx;
        logic [31:0] word;
        bit          h;
        word = a >> 2;
        idx  = int'(word % LINES);
        h    = model_line.exists(idx) && (model_line[idx] == word);
        if (h) begin
            model_hits = model_hits + 32'd1;
        end else begin
            model_misses    = model_misses + 32'd1;
            model_line[idx] = word;
        end
        return h;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // One complete CPU read: handshake, wait for data, check data/latency/memory traffic.
    task automatic run_req(input string name, input logic [31:0] a, input bit exp_hit,
                           input logic [31:0] exp_data);
        int n;
        bit saw_mem;
        int log_before;
        log_before    = mem_log.size();
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = a;
        #1;
        check1({name, " addr_ok"}, cpu_inst_addr_ok, 1'b1);
        @(posedge clk);
        #3;
        // Request still held: the cache must not take a second one while busy.
        check1({name, " addr_ok busy"}, cpu_inst_addr_ok, 1'b0);
        cpu_inst_req = 1'b0;
        n       = 1;
        saw_mem = 1'b0;
        while (!cpu_inst_data_ok && n < 64) begin
            if (cache_inst_req) saw_mem = 1'b1;
            tick();
            n++;
        end
        check1({name, " data_ok"}, cpu_inst_data_ok, 1'b1);
        check32({name, " rdata"}, cpu_inst_rdata, exp_data);
        if (exp_hit) check32({name, " hit latency"}, 32'(n), 32'd1);
        check1({name, " memory request"}, saw_mem, !exp_hit);
        if (!exp_hit) begin
            check32({name, " memory requests"}, 32'(mem_log.size() - log_before), 32'd1);
            if (mem_log.size() > log_before)
                check32({name, " memory addr"}, mem_log[$], {a[31:2], 2'b00});
        end
        tick();
        check1({name, " data_ok drop"}, cpu_inst_data_ok, 1'b0);
        check32({name, " rdata hold"}, cpu_inst_rdata, exp_data);
    endtask

    // Access whose expectations come from the reference model.
    task automatic access(input string name, input logic [31:0] a);
        bit h;
        h = model_access(a);
        run_req(name, a, h, mem_word({a[31:2], 2'b00}));
        check32({name, " hit_cnt"}, hit_cnt, model_hits);
        check32({name, " miss_cnt"}, miss_cnt, model_misses);
    endtask

    task automatic check_reset_outputs(input string name);
        check1({name, " addr_ok"}, cpu_inst_addr_ok, 1'b0);
        check1({name, " data_ok"}, cpu_inst_data_ok, 1'b0);
        check32({name, " rdata"}, cpu_inst_rdata, 32'd0);
        check1({name, " cache_req"}, cache_inst_req, 1'b0);
        check32({name, " cache_addr"}, cache_inst_addr, 32'd0);
        check32({name, " hit_cnt"}, hit_cnt, 32'd0);
        check32({name, " miss_cnt"}, miss_cnt, 32'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] addr;
        int          ad;
        int          dd;
        bit          exp_hit;
        logic [31:0] exp_data;
        logic [31:0] exp_hits;
        logic [31:0] exp_misses;
    } vec_t;

    vec_t vecs[6];

    logic [31:0] stream[4];

    initial begin
        int k, got, cyc, prev, n;
        bit saw_mem;
        logic [31:0] a;

        vecs[0] = '{32'h1FC0_0000, 2, 3, 1'b0, 32'h3C1D_0001,           32'd0, 32'd1};
        vecs[1] = '{32'h1FC0_0000, 0, 1, 1'b1, 32'h3C1D_0001,           32'd1, 32'd1};
        vecs[2] = '{32'h1FC0_1000, 1, 1, 1'b0, mem_word(32'h1FC0_1000), 32'd1, 32'd2};
        vecs[3] = '{32'h1FC0_0000, 0, 2, 1'b0, 32'h3C1D_0001,           32'd1, 32'd3};
        vecs[4] = '{32'h1FC0_0002, 0, 1, 1'b1, 32'h3C1D_0001,           32'd2, 32'd3};
        vecs[5] = '{32'h1FC0_1000, 3, 1, 1'b0, mem_word(32'h1FC0_1000), 32'd2, 32'd4};

        // Reset state.
        repeat (3) @(posedge clk);
        #3;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Cold miss, rehit, conflict misses, byte-offset hit.
        for (int i = 0; i < 6; i++) begin
            cur_ad = vecs[i].ad;
            cur_dd = vecs[i].dd;
            void'(model_access(vecs[i].addr));
            run_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_hit, vecs[i].exp_data);
            check32($sformatf("vec%0d hit_cnt", i), hit_cnt, vecs[i].exp_hits);
            check32($sformatf("vec%0d miss_cnt", i), miss_cnt, vecs[i].exp_misses);
        end

        // Reset while the refill is outstanding.
        cur_ad = 1;
        cur_dd = 20;
        cpu_inst_req  = 1'b1;
        cpu_inst_addr = 32'h1FC0_0004;
        tick();
        cpu_inst_req = 1'b0;
        n = 0;
        while (!mem_addr_ok && n < 20) begin
            tick();
            n++;
        end
        check1("refill reset handshake", mem_addr_ok, 1'b1);
        tick();
        rst          = 1'b1;
        cpu_inst_req = 1'b1;
        #1;
        check_reset_outputs("mid-refill reset");
        tick();
        cpu_inst_req = 1'b0;
        tick();
        rst = 1'b0;
        model_line.delete();
        model_hits   = '0;
        model_misses = '0;
        tick();
        cur_ad = 2;
        cur_dd = 3;
        access("post-reset", 32'h1FC0_0000);

        // Warm-up then streaming hits with the request held high.
        for (int i = 0; i < 4; i++) begin
            stream[i] = 32'h1FC0_0000 + 32'(4 * i);
            access($sformatf("warm%0d", i), stream[i]);
        end
        for (int i = 0; i < 4; i++) void'(model_access(stream[i]));
        k = 0; got = 0; cyc = 0; prev = 0; saw_mem = 1'b0;
        while (got < 4 && cyc < 40) begin
            cpu_inst_req  = (k < 4);
            cpu_inst_addr = stream[(k < 4) ? k : 3];
            #1;
            if (cache_inst_req) saw_mem = 1'b1;
            if (cpu_inst_data_ok) begin
                check32($sformatf("stream data%0d", got), cpu_inst_rdata, mem_word(stream[got]));
                got++;
            end
            if (cpu_inst_addr_ok) begin
                if (k > 0) check32($sformatf("stream spacing%0d", k), 32'(cyc - prev), 32'd2);
                prev = cyc;
                k++;
            end
            @(posedge clk);
            #3;
            cyc++;
        end
        cpu_inst_req = 1'b0;
        check32("stream responses", 32'(got), 32'd4);
        check1("stream memory idle", saw_mem, 1'b0);
        check32("stream hit_cnt", hit_cnt, model_hits);
        check32("stream miss_cnt", miss_cnt, model_misses);

        // Hit counter wrap.
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.hit_cnt_q;
        #1;
        check32("forced hit_cnt", hit_cnt, 32'hFFFF_FFFF);
        model_hits = 32'hFFFF_FFFF;
        access("wrap", 32'h1FC0_0008);

        // Randomized accesses over a small, aliasing address pool.
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = 32'h1FC0_0000 | 32'($urandom_range(0, 2) << 12)
                              | 32'($urandom_range(0, 7) << 2)
                              | 32'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) tick();
            access($sformatf("rand%0d", i), a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
